alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Initiator-side front end for the 8-bit, 4-bit-opcode combinational ALU.
- Accepts operation requests (op, x, y) on a valid/ready interface and queues them in a small FIFO.
- Issues each request to the ALU through registered operand and control outputs, waits a programmable settle time, then captures out and carry.
- Returns each result, in request order, on a valid/ready response interface. This lets multi-cycle or pipelined clients drive the ALU without holding operands stable themselves.

Parameters:
- DEPTH, 4, request FIFO depth in entries; power of 2, >= 2.
- SETTLE_CYC, 1, cycles the ALU inputs are held before the result is sampled; >= 1.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  FIFO can accept; equals !full.
- req_op  input  4  ALU control code, passed through unmodified.
- req_x  input  8  operand x.
- req_y  input  8  operand y.
- alu_x  output  8  registered operand to ALU x.
- alu_y  output  8  registered operand to ALU y.
- alu_cntrl  output  4  registered control to ALU cntrl.
- alu_out  input  8  ALU result.
- alu_carry  input  1  ALU carry/borrow.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_data  output  8  captured alu_out.
- rsp_carry  output  1  captured alu_carry.
- rsp_op  output  4  op that produced the result.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- busy  output  1  state != IDLE or count != 0.

Behaviour:
- Reset (async, rst_n low) values:
  - All outputs 0 except req_ready = 1; state = IDLE.
  - FIFO pointers and count cleared.
  - Reset asserted mid-operation drops the in-flight op and all queued ops.
  - rsp_valid falls immediately, without waiting for a clock edge.
- FIFO:
  - Push on req_valid && req_ready.
  - Pop only by the FSM, as described below.
  - Push and pop in the same cycle leaves count unchanged.
  - No push-through when full: req_ready is low at count == DEPTH even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETTLE, RESP.
  - IDLE:
    - If count != 0, pop the head and load alu_x/alu_y/alu_cntrl and an internal op register.
    - Load the settle counter with SETTLE_CYC-1; go to SETTLE.
  - SETTLE:
    - Hold all alu_* outputs stable.
    - While counter != 0, decrement.
    - When counter == 0, capture alu_out -> rsp_data, alu_carry -> rsp_carry, op -> rsp_op; set rsp_valid = 1; go to RESP.
  - RESP:
    - rsp_valid = 1; rsp_data/carry/op held stable while !rsp_ready.
    - On rsp_ready: if count != 0, pop the next entry in the same edge, reload the counter, go to SETTLE (back-to-back issue, no IDLE bubble); otherwise clear rsp_valid and go to IDLE.
    - If the next entry is popped, rsp_valid clears on that edge.
- Latency: request pushed into an empty FIFO at edge E0 while IDLE is popped at E1. rsp_valid rises at edge E1+SETTLE_CYC. With SETTLE_CYC = 1, rsp_valid rises 2 cycles after acceptance.
- Throughput: one result per SETTLE_CYC+1 cycles when rsp_ready is held high and the FIFO is non-empty.
- alu_* outputs keep their last values in IDLE; they do not return to 0.
- No arithmetic is performed in this block; widths pass through unchanged. Carry is captured raw for every op.
- Ordering: responses are strictly FIFO order. Maximum outstanding = DEPTH queued + 1 in flight.

Test Plan:
- Reset: assert rst_n = 0 mid-run -> same cycle rsp_valid = 0, count = 0, alu_x = alu_y = 0, alu_cntrl = 0, req_ready = 1.
- Single add, SETTLE_CYC = 1, behavioural ALU model on alu_*: op 0000, x = 0x4F, y = 0xA5 accepted at E0 -> rsp_valid at E2, rsp_data = 0xF4, rsp_carry = 0, rsp_op = 0000.
- Carry and order: push (0000, 0xFF, 0x01) then (0010, 0x4F, 0xA5), rsp_ready = 1 -> responses {0x00, carry 1, op 0000} then {0x05, carry 0, op 0010}, 2 cycles apart.
- Full/backpressure, DEPTH = 4: rsp_ready = 0, req_valid held high -> exactly 5 requests accepted, then req_ready = 0 and count = 4. rsp_data is stable over 10 cycles. Raise rsp_ready -> 5 responses in push order, with req_ready returning high one cycle after the first pop.
- Settle timing, SETTLE_CYC = 3: alu_cntrl/alu_x/alu_y unchanged for 3 cycles. Bench changes alu_out every cycle; the captured value is the one present in the 3rd SETTLE cycle.
- Async reset in SETTLE with 2 entries queued -> after release, no rsp_valid ever appears for the dropped ops. A new request (0001, 0x10, 0x01) completes normally.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-side and response signals of the ALU operation sequencer.
// slave is the sequencer's view; master is the client/ALU environment's view.
interface alu_op_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_x;
  logic [7:0] req_y;

  logic [7:0] alu_x;
  logic [7:0] alu_y;
  logic [3:0] alu_cntrl;
  logic [7:0] alu_out;
  logic       alu_carry;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic [3:0] rsp_op;

  modport slave (
    input  req_valid, req_op, req_x, req_y, alu_out, alu_carry, rsp_ready,
    output req_ready, alu_x, alu_y, alu_cntrl, rsp_valid, rsp_data, rsp_carry, rsp_op
  );

  modport master (
    output req_valid, req_op, req_x, req_y, alu_out, alu_carry, rsp_ready,
    input  req_ready, alu_x, alu_y, alu_cntrl, rsp_valid, rsp_data, rsp_carry, rsp_op
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU requests, holds operands on the ALU for SETTLE_CYC cycles,
// then returns the captured result in request order.
module alu_op_sequencer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_op_sequencer_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [AW:0]   FULL_LEVEL  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] x;
    logic [7:0] y;
  } entry_t;

  entry_t        mem_q [DEPTH];

  state_e        state_q,     state_d;
  logic [SW-1:0] cnt_q,       cnt_d;
  logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [AW:0]   count_q,     count_d;
  logic [7:0]    alu_x_q,     alu_x_d;
  logic [7:0]    alu_y_q,     alu_y_d;
  logic [3:0]    alu_cntrl_q, alu_cntrl_d;
  logic [3:0]    op_q,        op_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q,  rsp_data_d;
  logic          rsp_carry_q, rsp_carry_d;
  logic [3:0]    rsp_op_q,    rsp_op_d;

  logic   full;
  logic   push;
  logic   pop;
  entry_t head;

  always_comb begin
    full        = (count_q == FULL_LEVEL);
    push        = bus.req_valid && !full;
    head        = mem_q[rd_ptr_q];
    pop         = 1'b0;

    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    alu_cntrl_d = alu_cntrl_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_op_d    = rsp_op_q;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_data_d  = bus.alu_out;
          rsp_carry_d = bus.alu_carry;
          rsp_op_d    = op_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        // Next entry issues on the same edge the response is taken.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      alu_x_d     = head.x;
      alu_y_d     = head.y;
      alu_cntrl_d = head.op;
      op_d        = head.op;
      cnt_d       = SETTLE_LOAD;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{op: bus.req_op, x: bus.req_x, y: bus.req_y};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      alu_cntrl_q <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      alu_cntrl_q <= alu_cntrl_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_op_q    <= rsp_op_d;
    end
  end

  assign bus.req_ready = !full;
  assign bus.alu_x     = alu_x_q;
  assign bus.alu_y     = alu_y_q;
  assign bus.alu_cntrl = alu_cntrl_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_op    = rsp_op_q;
  assign count         = count_q;
  assign busy          = (state_q != IDLE) || (count_q != '0);

endmodule
